approx_mul_error_monitor: RTL and testbench

Sequential error-evaluation engine for approximate multiplier netlists. It drives every input vector of a combinational approximate multiplier, reads back the multiplier's outputs, and compares each one with the exact product. It accumulates worst-case error, total error and mismatch count, then flags whether the circuit meets its error threshold (ET). It sits on the consuming side of the approximate-circuit interface: the circuit under evaluation is combinational, and this block generates its stimulus and checks its response in silicon or emulation.

---
 rtl/approx_eval_pkg.sv | 35 +++
 rtl/approx_err_accum.sv | 77 +++++++
 rtl/approx_mul_error_monitor.sv | 133 +++++++++++++
 tb/tb_approx_mul_error_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// ---------------------------------------------------------------------------
// approx_eval_pkg
// Shared types and arithmetic helpers for the approximate-multiplier error
// monitor.
//   eval_state_t : sweep controller states
//   exact_mul    : reference product of the operands packed in a vector
//   abs_diff     : unsigned |a - b| by compare-and-subtract
// The helpers work on 32-bit containers so one definition serves every
// operand width. Callers truncate the results to their own widths.
// ---------------------------------------------------------------------------
package approx_eval_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } eval_state_t;

    // Operand A sits in vec[a_w-1:0] and operand B in the bits above it.
    // The caller passes only A_W+B_W meaningful bits, so a plain shift
    // isolates B.
    function automatic logic [63:0] exact_mul(input logic [31:0] vec, input int a_w);
        logic [31:0] op_a;
        logic [31:0] op_b;
        op_a = vec & ((32'd1 << a_w) - 32'd1);
        op_b = vec >> a_w;
        return {32'd0, op_a} * {32'd0, op_b};
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// ---------------------------------------------------------------------------
// approx_err_accum
// Error statistics registers for one sweep.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : zero all statistics (takes priority over upd)
//   upd           : fold err_in / vec_in into the statistics
//   err_in        : absolute error of the vector being checked
//   vec_in        : the vector being checked
//   max_err       : largest error seen so far
//   worst_vec     : first vector that produced max_err
//   sum_err       : running sum of errors
//   err_cnt       : number of vectors with a nonzero error
// ---------------------------------------------------------------------------
module approx_err_accum #(
    parameter int VEC_W = 4,
    parameter int ERR_W = 4,
    parameter int SUM_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [ERR_W-1:0] err_in,
    input  logic [VEC_W-1:0] vec_in,
    output logic [ERR_W-1:0] max_err,
    output logic [VEC_W-1:0] worst_vec,
    output logic [SUM_W-1:0] sum_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [ERR_W-1:0] max_q,   max_d;
    logic [VEC_W-1:0] worst_q, worst_d;
    logic [SUM_W-1:0] sum_q,   sum_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        max_d   = max_q;
        worst_d = worst_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (clr) begin
            max_d   = '0;
            worst_d = '0;
            sum_d   = '0;
            cnt_d   = '0;
        end else if (upd) begin
            // Strict greater-than so a tie keeps the earlier vector.
            if (err_in > max_q) begin
                max_d   = err_in;
                worst_d = vec_in;
            end
            sum_d = sum_q + SUM_W'(err_in);
            cnt_d = cnt_q + CNT_W'(err_in != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q   <= '0;
            worst_q <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            max_q   <= max_d;
            worst_q <= worst_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign max_err   = max_q;
    assign worst_vec = worst_q;
    assign sum_err   = sum_q;
    assign err_cnt   = cnt_q;

endmodule

// File: rtl/approx_mul_error_monitor.sv
// ---------------------------------------------------------------------------
// approx_mul_error_monitor
// Sweeps every input vector of a combinational approximate multiplier,
// compares each response with the exact truncated product and reports
// error statistics plus a pass/fail against the threshold ET.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sweep (only honoured while idle)
//   busy       : sweep in progress
//   done       : one-cycle pulse, results valid
//   dut_in     : registered stimulus {B, A} to the circuit
//   dut_out    : circuit response
//   max_err    : largest |approx - exact|
//   worst_vec  : first vector that produced max_err
//   sum_err    : sum of absolute errors
//   err_cnt    : vectors with a nonzero error
//   pass       : max_err <= ET, valid from the done pulse onward
// Each vector takes two cycles: DRIVE gives the circuit a full cycle to
// settle, and CHECK samples its output.
// ---------------------------------------------------------------------------
module approx_mul_error_monitor
    import approx_eval_pkg::*;
#(
    parameter int A_W   = 2,
    parameter int B_W   = 2,
    parameter int OUT_W = 4,
    parameter int ET    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [A_W+B_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]         dut_out,
    output logic [OUT_W-1:0]         max_err,
    output logic [A_W+B_W-1:0]       worst_vec,
    output logic [OUT_W+A_W+B_W-1:0] sum_err,
    output logic [A_W+B_W:0]         err_cnt,
    output logic                     pass
);

    localparam int          VEC_W = A_W + B_W;
    localparam logic [31:0] ET_U  = 32'(ET);

    eval_state_t      state_q, state_d;
    logic [VEC_W-1:0] vec_q,   vec_d;
    logic             pass_q,  pass_d;

    logic             acc_clr;
    logic             acc_upd;
    logic [OUT_W-1:0] exact_val;
    logic [OUT_W-1:0] err_val;
    logic             max_ok;

    assign exact_val = OUT_W'(exact_mul(32'(vec_q), A_W));
    assign err_val   = OUT_W'(abs_diff(32'(dut_out), 32'(exact_val)));
    assign max_ok    = (32'(max_err) <= ET_U);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pass_d  = pass_q;
        acc_clr = 1'b0;
        acc_upd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    acc_clr = 1'b1;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                acc_upd = 1'b1;
                if (&vec_q) begin
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = DRIVE;
                end
            end
            FINISH: begin
                pass_d  = max_ok;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pass_q  <= pass_d;
        end
    end

    approx_err_accum #(
        .VEC_W (VEC_W),
        .ERR_W (OUT_W),
        .SUM_W (OUT_W + VEC_W),
        .CNT_W (VEC_W + 1)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .upd       (acc_upd),
        .err_in    (err_val),
        .vec_in    (vec_q),
        .max_err   (max_err),
        .worst_vec (worst_vec),
        .sum_err   (sum_err),
        .err_cnt   (err_cnt)
    );

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH);
    assign dut_in = vec_q;
    // The final max_err is already settled during FINISH, so pass is shown
    // straight from the compare in the done cycle and held in pass_q after.
    assign pass   = done ? max_ok : pass_q;

endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_error_monitor
// Two monitors (ET=8 and ET=7) each evaluate a circuit modelled as a
// 16-entry lookup table. Fixed circuits come from a vector table. Random
// circuits are checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_approx_mul_error_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] lut [16];

    logic       busy8, done8, pass8;
    logic [3:0] dut_in8, dut_out8, max8, worst8;
    logic [7:0] sum8;
    logic [4:0] cnt8;

    logic       busy7, done7, pass7;
    logic [3:0] dut_in7, dut_out7, max7, worst7;
    logic [7:0] sum7;
    logic [4:0] cnt7;

    always #5 clk = ~clk;

    always_comb dut_out8 = lut[dut_in8];
    always_comb dut_out7 = lut[dut_in7];

    approx_mul_error_monitor #(.A_W(2), .B_W(2), .OUT_W(4), .ET(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy8), .done(done8),
        .dut_in(dut_in8), .dut_out(dut_out8), .max_err(max8),
        .worst_vec(worst8), .sum_err(sum8), .err_cnt(cnt8), .pass(pass8)
    );

    approx_mul_error_monitor #(.A_W(2), .B_W(2), .OUT_W(4), .ET(7)) u_dut7 (
        .clk(clk), .rst(rst), .start(start), .busy(busy7), .done(done7),
        .dut_in(dut_in7), .dut_out(dut_out7), .max_err(max7),
        .worst_vec(worst7), .sum_err(sum7), .err_cnt(cnt7), .pass(pass7)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Values captured during a sweep
    int r_max, r_worst, r_sum, r_cnt, r_pass8, r_pass7, r_pass8_late;
    int done_cyc, n_done, busy_c1, busy_c34;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // kind 0: exact product, 1: constant, 2: exact product xor 4'b1000
    task automatic fill_lut(input int kind, input int cval);
        for (int v = 0; v < 16; v++) begin
            int ex;
            ex = ((v % 4) * (v / 4)) % 16;
            case (kind)
                0:       lut[v] = 4'(ex);
                1:       lut[v] = 4'(cval);
                default: lut[v] = 4'(ex ^ 8);
            endcase
        end
    endtask

    // Reference: walk all operand pairs with integer arithmetic.
    task automatic model(output int mx, output int wv, output int sm, output int ct);
        mx = 0; wv = 0; sm = 0; ct = 0;
        for (int v = 0; v < 16; v++) begin
            int ex, ap, e;
            ex = ((v % 4) * (v / 4)) % 16;
            ap = int'(lut[v]);
            e  = (ap > ex) ? ap - ex : ex - ap;
            if (e > mx) begin mx = e; wv = v; end
            sm += e;
            if (e != 0) ct++;
        end
    endtask

    // Pulse start, then watch 40 cycles. Cycle 0 is the one where start is
    // sampled. extra_cyc > 0 raises start again during that cycle.
    task automatic run_sweep(input int extra_cyc);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_cyc = -1; n_done = 0; busy_c1 = -1; busy_c34 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1)  busy_c1  = int'(busy8);
            if (c == 34) busy_c34 = int'(busy8);
            if (done8) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    r_max = int'(max8); r_worst = int'(worst8);
                    r_sum = int'(sum8); r_cnt = int'(cnt8);
                    r_pass8 = int'(pass8); r_pass7 = int'(pass7);
                end
            end
            start = (c == extra_cyc);
        end
        r_pass8_late = int'(pass8);
        if (done_cyc < 0) begin
            r_max = -1; r_worst = -1; r_sum = -1; r_cnt = -1; r_pass8 = -1; r_pass7 = -1;
        end
    endtask

    task automatic check_sweep(input string tag, input int emx, input int ewv,
                               input int esm, input int ect, input int ep8, input int ep7);
        $display("sweep %s: max=%0d worst=%0h sum=%0d cnt=%0d pass8=%0d pass7=%0d done@%0d",
                 tag, r_max, r_worst, r_sum, r_cnt, r_pass8, r_pass7, done_cyc);
        chk({tag, ".done_cycle"}, done_cyc, 33);
        chk({tag, ".done_pulses"}, n_done, 1);
        chk({tag, ".busy_c1"}, busy_c1, 1);
        chk({tag, ".busy_c34"}, busy_c34, 0);
        chk({tag, ".max_err"}, r_max, emx);
        chk({tag, ".worst_vec"}, r_worst, ewv);
        chk({tag, ".sum_err"}, r_sum, esm);
        chk({tag, ".err_cnt"}, r_cnt, ect);
        chk({tag, ".pass_et8"}, r_pass8, ep8);
        chk({tag, ".pass_et7"}, r_pass7, ep7);
        chk({tag, ".pass_held"}, r_pass8_late, ep8);
    endtask

    typedef struct {
        string name;
        int    kind;
        int    cval;
        int    e_max, e_worst, e_sum, e_cnt, e_pass8, e_pass7;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{"exact", 0, 0,   0, 0,   0,  0, 1, 1};
        tbl[1] = '{"zero",  1, 0,   9, 15,  36, 9, 0, 0};
        tbl[2] = '{"ones",  1, 15, 15, 0, 204, 16, 0, 0};
        tbl[3] = '{"xor8",  2, 0,   8, 0, 128, 16, 1, 0};

        rst = 1'b1; start = 1'b0;
        fill_lut(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", busy8, 0);
        chk("reset.done", done8, 0);
        chk("reset.dut_in", dut_in8, 0);
        chk("reset.max_err", max8, 0);
        chk("reset.worst_vec", worst8, 0);
        chk("reset.sum_err", sum8, 0);
        chk("reset.err_cnt", cnt8, 0);
        chk("reset.pass", pass8, 0);

        // rst and start together: reset wins, nothing starts
        start = 1'b1;
        @(negedge clk);
        chk("rst_start.busy", busy8, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start.busy_after", busy8, 0);

        for (int i = 0; i < 4; i++) begin
            fill_lut(tbl[i].kind, tbl[i].cval);
            run_sweep(0);
            check_sweep(tbl[i].name, tbl[i].e_max, tbl[i].e_worst, tbl[i].e_sum,
                        tbl[i].e_cnt, tbl[i].e_pass8, tbl[i].e_pass7);
        end

        for (int i = 0; i < 6; i++) begin
            int mx, wv, sm, ct;
            for (int v = 0; v < 16; v++) lut[v] = 4'($urandom_range(0, 15));
            model(mx, wv, sm, ct);
            run_sweep(0);
            check_sweep($sformatf("rand%0d", i), mx, wv, sm, ct,
                        (mx <= 8) ? 1 : 0, (mx <= 7) ? 1 : 0);
        end

        // Sweep interrupted by rst at cycle 10
        fill_lut(1, 15);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        $display("sweep rst_abort: busy=%0d done=%0d max=%0d sum=%0d cnt=%0d",
                 busy8, done8, max8, sum8, cnt8);
        chk("abort.busy", busy8, 0);
        chk("abort.done", done8, 0);
        chk("abort.dut_in", dut_in8, 0);
        chk("abort.max_err", max8, 0);
        chk("abort.worst_vec", worst8, 0);
        chk("abort.sum_err", sum8, 0);
        chk("abort.err_cnt", cnt8, 0);
        chk("abort.pass", pass8, 0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (done8 || busy8) seen++;
            end
            chk("abort.no_done", seen, 0);
        end
        // Restart with a stray start pulse at cycle 5; it must be ignored
        run_sweep(5);
        check_sweep("restart", 15, 0, 204, 16, 0, 0);

        // start held high: a new sweep begins right after FINISH
        fill_lut(0, 0);
        begin
            int dc, b34, b35, d35, fin;
            dc = -1; b34 = -1; b35 = -1; d35 = -1; fin = 0;
            @(negedge clk); start = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= 35; c++) begin
                @(negedge clk);
                if (done8 && dc < 0) dc = c;
                if (c == 34) b34 = int'(busy8);
                if (c == 35) begin b35 = int'(busy8); d35 = int'(dut_in8); end
            end
            start = 1'b0;
            for (int c = 0; c < 80 && fin == 0; c++) begin
                @(negedge clk);
                if (done8) fin = 1;
            end
            $display("sweep held_start: done@%0d busy34=%0d busy35=%0d dut_in35=%0d second_done=%0d",
                     dc, b34, b35, d35, fin);
            chk("held.done_cycle", dc, 33);
            chk("held.busy_c34", b34, 0);
            chk("held.busy_c35", b35, 1);
            chk("held.dut_in_c35", d35, 0);
            chk("held.second_done", fin, 1);
            chk("held.pass", pass8, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
